// File: rtl/cache_defs.sv
// Definitions shared by the instruction cache and the planned data cache:
// controller state encodings, field widths and the block word selector.
package cache_defs;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] READ   = 2'd1;
   localparam logic [1:0] UPDATE = 2'd2;

   localparam int OFFSET_W = 2;
   localparam int INDEX_W  = 3;
   localparam int TAG_W    = 3;
   localparam int BLOCK_W  = 128;
   localparam int WORD_W   = 32;

   typedef logic [BLOCK_W-1:0] block_t;
   typedef logic [WORD_W-1:0]  word_t;

   function automatic word_t word_sel(input block_t blk, input logic [OFFSET_W-1:0] off);
      return blk[off*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side (PC/INSTRUCTION/BUSYWAIT) and memory-side block read signals.
interface instruction_cache_if
   import cache_defs::*;
#(
   parameter int ADDR_BITS = 10
);

   logic [31:0]          PC;
   logic [WORD_W-1:0]    INSTRUCTION;
   logic                 BUSYWAIT;
   logic                 MEM_READ;
   logic [ADDR_BITS-5:0] MEM_ADDRESS;
   logic [BLOCK_W-1:0]   MEM_READDATA;
   logic                 MEM_BUSYWAIT;

   modport slave (
      input  PC, MEM_READDATA, MEM_BUSYWAIT,
      output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );

   modport master (
      output PC, MEM_READDATA, MEM_BUSYWAIT,
      input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );

endinterface

// File: rtl/cache_ctrl_fsm.sv
// Miss-handling controller: IDLE -> READ (wait for memory) -> UPDATE -> IDLE.
// Reset aborts any transaction at the posedge it is sampled.
module cache_ctrl_fsm
   import cache_defs::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_hit,
   input  logic       i_mem_busywait,
   output logic [1:0] o_state,
   output logic       o_mem_read,
   output logic       o_busywait,
   output logic       o_line_we,
   output logic       o_buf_load
);

   logic [1:0] r_state;
   logic [1:0] w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (!i_hit)          w_next = READ;
         READ:    if (!i_mem_busywait) w_next = UPDATE;
         UPDATE:                       w_next = IDLE;
         default:                      w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   assign o_state    = r_state;
   assign o_mem_read = (r_state == READ);
   // Masking with reset keeps a simultaneous reset from writing a line.
   assign o_busywait = !i_rst && ((r_state != IDLE) || !i_hit);
   assign o_buf_load = !i_rst && (r_state == READ) && !i_mem_busywait;
   assign o_line_we  = !i_rst && (r_state == UPDATE);

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path,
// 128-bit block refill from instruction memory on a miss.
module instruction_cache
   import cache_defs::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int ADDR_BITS  = 10
)(
   input  logic                CLK,
   input  logic                RESET,
   instruction_cache_if.slave  bus
);

   localparam int IDX_W    = $clog2(NUM_BLOCKS);
   localparam int TAG_BITS = ADDR_BITS - OFFSET_W - 2 - IDX_W;

   logic [OFFSET_W-1:0] w_offset;
   logic [IDX_W-1:0]    w_index;
   logic [TAG_BITS-1:0] w_tag;
   logic                w_hit;
   logic [1:0]          w_state;
   logic                w_mem_read;
   logic                w_busywait;
   logic                w_line_we;
   logic                w_buf_load;
   logic                w_unused_pc;

   logic [NUM_BLOCKS-1:0] r_valid;
   logic [TAG_BITS-1:0]   r_tag  [NUM_BLOCKS];
   block_t                r_data [NUM_BLOCKS];
   block_t                r_block;

   assign w_offset    = bus.PC[2 +: OFFSET_W];
   assign w_index     = bus.PC[4 +: IDX_W];
   assign w_tag       = bus.PC[4 + IDX_W +: TAG_BITS];
   assign w_unused_pc = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};

   assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

   cache_ctrl_fsm u_fsm (
      .i_clk          (CLK),
      .i_rst          (RESET),
      .i_hit          (w_hit),
      .i_mem_busywait (bus.MEM_BUSYWAIT),
      .o_state        (w_state),
      .o_mem_read     (w_mem_read),
      .o_busywait     (w_busywait),
      .o_line_we      (w_line_we),
      .o_buf_load     (w_buf_load)
   );

   always_ff @(posedge CLK) begin
      if (RESET)          r_valid <= '0;
      else if (w_line_we) r_valid[w_index] <= 1'b1;
   end

   // Tag and data arrays carry no reset; the valid bits alone gate hits.
   always_ff @(posedge CLK) begin
      if (w_buf_load) r_block <= bus.MEM_READDATA;
      if (w_line_we) begin
         r_tag[w_index]  <= w_tag;
         r_data[w_index] <= r_block;
      end
   end

   assign bus.BUSYWAIT    = w_busywait;
   assign bus.MEM_READ    = w_mem_read;
   assign bus.MEM_ADDRESS = (w_state == READ) ? bus.PC[4 +: ADDR_BITS-4] : '0;
   assign bus.INSTRUCTION = RESET ? '0 : word_sel(r_data[w_index], w_offset);

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios followed by
// random accesses, checked against a line-level cache model.
module tb_instruction_cache;

   logic CLK;
   logic RESET;

   instruction_cache_if #(.ADDR_BITS(10)) bus ();

   instruction_cache #(.NUM_BLOCKS(8), .ADDR_BITS(10)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [127:0] mem    [64];
   logic         mvalid [8];
   logic [2:0]   mtag   [8];
   logic [127:0] mdata  [8];

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] pc);
      logic [127:0] blk;
      logic [1:0]   off;
      blk = mdata[pc[6:4]];
      off = pc[3:2];
      return blk[32*off +: 32];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
   endtask

   // One CPU fetch: presents pc (and releases reset) at a negedge, then
   // plays memory with busy_n busy cycles until BUSYWAIT falls.
   task automatic access(input logic [31:0] pc, input int unsigned busy_n);
      logic [2:0]  idx;
      logic [2:0]  tg;
      logic        hit;
      int unsigned bw;
      int unsigned rd;
      logic        done;
      idx = pc[6:4];
      tg  = pc[9:7];
      hit = mvalid[idx] && (mtag[idx] == tg);
      @(negedge CLK);
      RESET            = 1'b0;
      bus.PC           = pc;
      bus.MEM_BUSYWAIT = (busy_n != 0);
      bus.MEM_READDATA = rand128();
      #1;
      check("busywait_first", bus.BUSYWAIT, !hit);
      check("mem_read_idle", bus.MEM_READ, 1'b0);
      check("mem_addr_idle", bus.MEM_ADDRESS, 6'd0);
      if (hit) begin
         check("instr_hit", bus.INSTRUCTION, model_word(pc));
         return;
      end
      bw   = 1;
      rd   = 0;
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge CLK);
         #1;
         if (!bus.BUSYWAIT) begin
            done = 1'b1;
         end else begin
            bw++;
            if (bus.MEM_READ) begin
               rd++;
               check("mem_addr_read", bus.MEM_ADDRESS, pc[9:4]);
               if (rd > busy_n) begin
                  bus.MEM_BUSYWAIT = 1'b0;
                  bus.MEM_READDATA = mem[pc[9:4]];
               end else begin
                  bus.MEM_BUSYWAIT = 1'b1;
                  bus.MEM_READDATA = rand128();
               end
            end else begin
               check("mem_addr_update", bus.MEM_ADDRESS, 6'd0);
               bus.MEM_BUSYWAIT = 1'b1;
               bus.MEM_READDATA = rand128();
            end
         end
      end
      check("miss_timeout", done, 1'b1);
      check("busywait_len", bw, busy_n + 3);
      check("mem_read_len", rd, busy_n + 1);
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdata[idx]  = mem[pc[9:4]];
      check("instr_fill", bus.INSTRUCTION, model_word(pc));
      check("mem_read_after", bus.MEM_READ, 1'b0);
   endtask

   // Starts a miss on pc and asserts reset during READ cycle n, together
   // with memory completing, so the returned block must be discarded.
   task automatic reset_mid_read(input logic [31:0] pc, input int unsigned n);
      @(negedge CLK);
      bus.PC           = pc;
      bus.MEM_BUSYWAIT = 1'b1;
      #1;
      check("rst_test_miss", bus.BUSYWAIT, 1'b1);
      for (int unsigned k = 1; k <= n; k++) begin
         @(negedge CLK);
         #1;
         check("rst_test_read", bus.MEM_READ, 1'b1);
      end
      RESET            = 1'b1;
      bus.MEM_BUSYWAIT = 1'b0;
      bus.MEM_READDATA = mem[pc[9:4]];
      #1;
      check("rst_busywait", bus.BUSYWAIT, 1'b0);
      check("rst_instr", bus.INSTRUCTION, 32'd0);
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = rand128();
      mem[0]    = {32'h03000001, 32'h02010203, 32'h00000705, 32'h00020004};
      RESET            = 1'b1;
      bus.PC           = 32'h0;
      bus.MEM_BUSYWAIT = 1'b1;
      bus.MEM_READDATA = '0;
      model_reset();

      repeat (2) @(negedge CLK);
      bus.PC = 32'h0000_0004;
      #1;
      check("reset_busywait", bus.BUSYWAIT, 1'b0);
      check("reset_instr", bus.INSTRUCTION, 32'd0);
      check("reset_mem_read", bus.MEM_READ, 1'b0);
      check("reset_mem_addr", bus.MEM_ADDRESS, 6'd0);

      // Cold miss, then spatial hits within the same block.
      access(32'h000, 4);
      check("cold_w0", bus.INSTRUCTION, 32'h00020004);
      access(32'h004, 0);
      check("hit_w1", bus.INSTRUCTION, 32'h00000705);
      access(32'h008, 0);
      check("hit_w2", bus.INSTRUCTION, 32'h02010203);
      access(32'h00C, 0);
      check("hit_w3", bus.INSTRUCTION, 32'h03000001);

      // Conflict eviction on index 0.
      access(32'h080, 2);
      access(32'h000, 1);
      access(32'h004, 0);

      // Reset during the second READ cycle; line must stay invalid.
      reset_mid_read(32'h010, 2);
      access(32'h010, 2);
      access(32'h000, 1);

      // Zero-wait memory at the top of the address space, then aliasing.
      access(32'h3FC, 0);
      access(32'hFFFF_FFFC, 0);
      access(32'h0000_07F8, 0);

      for (int n = 0; n < 80; n++) begin
         logic [31:0] pc;
         pc = $urandom;
         pc[9:7] = 3'($urandom_range(0, 1));
         access(pc, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
